// File: rtl/downsampling_pkg.sv
// Shared FSM encoding and geometry constants for the 2x2 box-filter downsampler.
package downsampling_pkg;

    localparam int unsigned DEF_IMG_W = 64;
    localparam int unsigned DEF_IMG_H = 64;
    localparam int unsigned OUT_W     = DEF_IMG_W / 2;
    localparam int unsigned OUT_H     = DEF_IMG_H / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R0,
        S_R1,
        S_R2,
        S_R3,
        S_LAST,
        S_WR,
        S_DONE
    } state_e;

    function automatic int unsigned half_dim(input int unsigned dim);
        return dim / 2;
    endfunction

endpackage

// File: rtl/downsampling_addr_gen.sv
// Output row/column counters plus source and destination address generation.
module downsampling_addr_gen
    import downsampling_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              step_i,
    input  logic              clear_i,
    input  logic              rd_sel_i,
    input  logic              wr_sel_i,
    input  logic              dy_i,
    input  logic              dx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              last_o
);

    localparam int unsigned COLS = half_dim(IMG_W);
    localparam int unsigned ROWS = half_dim(IMG_H);

    logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
    logic [ADDR_W-1:0] src_row, src_col, rd_calc, wr_calc;
    logic              col_end;

    assign col_end = (c_q == ADDR_W'(COLS - 1));
    assign last_o  = col_end && (r_q == ADDR_W'(ROWS - 1));

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clear_i) begin
            r_d = '0;
            c_d = '0;
        end else if (step_i && !last_o) begin
            if (col_end) begin
                c_d = '0;
                r_d = r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    // Source pixel (2r+dy, 2c+dx); doubling is a shift with dy/dx in the LSB.
    always_comb begin
        src_row = (r_q << 1) | ADDR_W'(dy_i);
        src_col = (c_q << 1) | ADDR_W'(dx_i);
        rd_calc = src_row * ADDR_W'(IMG_W) + src_col;
        wr_calc = r_q * ADDR_W'(COLS) + c_q;
    end

    assign rd_addr_o = rd_sel_i ? rd_calc : '0;
    assign wr_addr_o = wr_sel_i ? wr_calc : '0;

endmodule

// File: rtl/downsampling_controller.sv
// Frame sequencer: reads each 2x2 source block, accumulates it and writes the rounded mean.
module downsampling_controller
    import downsampling_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wren,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [DATA_W+1:0]   acc_q, acc_d;
    logic                dy, dx, last_px;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dy      = 1'b0;
        dx      = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_R0;
            S_R0:   state_d = S_R1;
            S_R1: begin
                dx      = 1'b1;
                acc_d   = {2'b00, rd_data};
                state_d = S_R2;
            end
            S_R2: begin
                dy      = 1'b1;
                acc_d   = acc_q + {2'b00, rd_data};
                state_d = S_R3;
            end
            S_R3: begin
                dy      = 1'b1;
                dx      = 1'b1;
                acc_d   = acc_q + {2'b00, rd_data};
                state_d = S_LAST;
            end
            S_LAST: begin
                acc_d   = acc_q + {2'b00, rd_data};
                state_d = S_WR;
            end
            S_WR:   state_d = last_px ? S_DONE : S_R0;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked by reset so an aborted frame emits nothing in the reset cycle itself.
    assign rd_en   = !reset && (state_q inside {S_R0, S_R1, S_R2, S_R3});
    assign wren    = !reset && (state_q == S_WR);
    assign done    = !reset && (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);
    assign wr_data = wren ? DATA_W'((acc_q + (DATA_W+2)'(2)) >> 2) : '0;

    downsampling_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i     (clk),
        .reset_i   (reset),
        .step_i    (state_q == S_WR),
        .clear_i   (state_q == S_DONE),
        .rd_sel_i  (rd_en),
        .wr_sel_i  (wren),
        .dy_i      (dy),
        .dx_i      (dx),
        .rd_addr_o (rd_addr),
        .wr_addr_o (wr_addr),
        .last_o    (last_px)
    );

endmodule

// File: tb/tb_downsampling_controller.sv
// Directed-vector bench for downsampling_controller on a 4x4 source image.
module tb_downsampling_controller;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wren;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] src [16];
    int wa[$];
    int wd[$];
    int ra[$];
    int done_cnt    = 0;
    int overlap_err = 0;
    int addr_err    = 0;
    int n_vec       = 0;
    int n_bad       = 0;
    int done_cyc;

    downsampling_controller #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wren    (wren),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Source memory with one cycle of read latency.
    always @(posedge clk) rd_data <= rd_en ? src[rd_addr] : '0;

    always @(negedge clk) begin
        if (wren) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
        end
        if (rd_en) ra.push_back(int'(rd_addr));
        if (done) done_cnt++;
        if (rd_en && wren) overlap_err++;
        if ((!rd_en && rd_addr != '0) || (!wren && wr_addr != '0)) addr_err++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        ra.delete();
        done_cnt    = 0;
        overlap_err = 0;
        addr_err    = 0;
    endtask

    // Cycle 0 is the cycle in which start is sampled; returns the cycle done is seen (0 on timeout).
    task automatic run_frame(input bit hold, output int dcyc);
        dcyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                dcyc = n;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int dcyc,
                               input int e0, input int e1, input int e2, input int e3);
        int exp_d[4];
        exp_d = '{e0, e1, e2, e3};
        @(posedge clk);
        #1;
        check_eq({tag, "_done_cycle"}, dcyc, 25);
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_writes"}, wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                check_eq($sformatf("%s_waddr%0d", tag, i), wa[i], i);
                check_eq($sformatf("%s_wdata%0d", tag, i), wd[i], exp_d[i]);
            end
        end
        check_eq({tag, "_overlap"}, overlap_err, 0);
        check_eq({tag, "_idle_addr"}, addr_err, 0);
        check_eq({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) src[i] = DATA_W'(v);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rden", int'(rd_en), 0);
        check_eq("rst_wren", int'(wren), 0);
        check_eq("rst_raddr", int'(rd_addr), 0);
        check_eq("rst_waddr", int'(wr_addr), 0);
        reset = 1'b0;

        // Uniform 100 image.
        fill(100);
        clear_logs();
        run_frame(1'b0, done_cyc);
        check_frame("flat100", done_cyc, 100, 100, 100, 100);

        // Rounding: sums 5 -> 1 and 7 -> 2, lower blocks zero.
        fill(0);
        src[0] = 1; src[1] = 1; src[4] = 1; src[5] = 2;
        src[2] = 1; src[3] = 2; src[6] = 2; src[7] = 2;
        clear_logs();
        run_frame(1'b0, done_cyc);
        check_frame("round", done_cyc, 1, 2, 0, 0);

        // Full-scale pixels must not overflow.
        fill(255);
        clear_logs();
        run_frame(1'b0, done_cyc);
        check_frame("max255", done_cyc, 255, 255, 255, 255);

        // Ramp p(y,x) = 4y+x.
        for (int i = 0; i < 16; i++) src[i] = DATA_W'(i);
        clear_logs();
        run_frame(1'b0, done_cyc);
        check_frame("ramp", done_cyc, 3, 5, 11, 13);
        check_eq("ramp_nreads", ra.size(), 16);
        if (ra.size() >= 4) begin
            check_eq("ramp_raddr0", ra[0], 0);
            check_eq("ramp_raddr1", ra[1], 1);
            check_eq("ramp_raddr2", ra[2], 4);
            check_eq("ramp_raddr3", ra[3], 5);
        end

        // Abort in the WR cycle of the second output pixel (cycle 12).
        fill(100);
        clear_logs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check_eq("abort_in_wr", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_eq("abort_wren", int'(wren), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_writes", wa.size(), 1);
        check_eq("abort_done", done_cnt, 0);
        clear_logs();
        run_frame(1'b0, done_cyc);
        check_frame("rerun", done_cyc, 100, 100, 100, 100);

        // start held high: one frame per IDLE pass, restart only from IDLE.
        clear_logs();
        run_frame(1'b1, done_cyc);
        check_eq("hold_done_cycle", done_cyc, 25);
        check_eq("hold_writes", wa.size(), 4);
        @(posedge clk);
        #1;
        check_eq("hold_idle_busy", int'(busy), 0);
        check_eq("hold_done_pulses", done_cnt, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("hold_restart_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // start dropped before the IDLE cycle: no restart.
        clear_logs();
        run_frame(1'b1, done_cyc);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drop_idle_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        check_eq("drop_no_restart", int'(busy), 0);
        check_eq("drop_done_pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/downsampling_controller.md
DOWNSAMPLING_CONTROLLER -- requirements
Module: downsampling_controller

Interface
REQ-001 Parameter IMG_W, default 64, meaning source image width in pixels (even, >=2).
REQ-002 Parameter IMG_H, default 64, meaning source image height in pixels (even, >=2).
REQ-003 Parameter DATA_W, default 8, meaning pixel width in bits.
REQ-004 Parameter ADDR_W, default 12, meaning read and write address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin one full-frame downsampling pass.
REQ-008 rd_en  output  1  source-memory read strobe.
REQ-009 rd_addr  output  ADDR_W  source-memory read address.
REQ-010 rd_data  input  DATA_W  source pixel, valid the cycle after rd_en.
REQ-011 wren  output  1  destination-memory write enable.
REQ-012 wr_addr  output  ADDR_W  destination-memory write address.
REQ-013 wr_data  output  DATA_W  downsampled pixel.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-016 The block SHALL produce an (IMG_W/2) x (IMG_H/2) output, each pixel the rounded mean of a 2x2 source block: out(r,c) = (p(2r,2c)+p(2r,2c+1)+p(2r+1,2c)+p(2r+1,2c+1)+2) >> 2.
REQ-017 The accumulator SHALL be DATA_W+2 bits; no saturation is needed (max result 2^DATA_W-1).
REQ-018 The FSM SHALL have states IDLE, R0, R1, R2, R3, LAST, WR, DONE.
REQ-019 IDLE -> R0 when start=1, else stay; start SHALL be ignored in every other state.
REQ-020 R0..R3 SHALL assert rd_en with rd_addr = (2r+dy)*IMG_W + 2c+dx, (dy,dx) = (0,0),(0,1),(1,0),(1,1) respectively.
REQ-021 R1 SHALL load the accumulator with rd_data; R2, R3, LAST SHALL add rd_data (1-cycle read latency).
REQ-022 R0->R1->R2->R3->LAST->WR unconditionally.
REQ-023 WR SHALL assert wren for exactly one cycle with wr_addr = r*(IMG_W/2)+c and wr_data per REQ-016.
REQ-024 WR -> DONE when c = IMG_W/2-1 and r = IMG_H/2-1; else WR -> R0 with c+1, or c=0 and r+1 on column wrap.
REQ-025 DONE SHALL assert done for one cycle, clear r and c, and go to IDLE.
REQ-026 Output pixels SHALL be written in raster order; each pixel takes 6 cycles; start sampled in cycle 0 gives done in cycle 6*(IMG_W/2)*(IMG_H/2)+1.
REQ-027 rd_en and wren SHALL never be high in the same cycle; rd_addr/wr_addr SHALL be 0 when their strobe is low.

Reset
REQ-028 reset SHALL, on the next rising edge, force state IDLE, r=c=0, accumulator=0, and all outputs 0.
REQ-029 Reset mid-frame SHALL abort with no further wren, and done SHALL NOT pulse for the aborted frame.
REQ-030 reset SHALL take priority over start in the same cycle.

Structure
REQ-031 Package downsampling_pkg SHALL hold the state enumeration and the derived constants OUT_W=IMG_W/2, OUT_H=IMG_H/2.
REQ-032 A sub-module downsampling_addr_gen SHALL hold the r/c counters and compute rd_addr and wr_addr; the FSM and accumulator SHALL reside in downsampling_controller.

Verification
REQ-033 IMG_W=IMG_H=4, all pixels 100, start pulse -> 4 writes, addresses 0,1,2,3, all data 100; done in cycle 25.
REQ-034 2x2 block pixels 1,1,1,2 -> wr_data 1; pixels 1,2,2,2 -> wr_data 2 (rounding check).
REQ-035 All pixels 255 -> every wr_data 255; no overflow.
REQ-036 Source pixel p(y,x)=y*4+x on a 4x4 image -> wr_data 3,5,11,13 at wr_addr 0..3, with rd_addr sequence 0,1,4,5 for the first output.
REQ-037 Reset asserted in WR of the second pixel -> no wren that cycle or after, busy=0, done never pulses; a new start then repeats REQ-033 exactly.
REQ-038 start held high through the whole frame -> exactly one frame, one done pulse; a new frame starts only if start is still high in the IDLE cycle that follows.
